// File: rtl/ws2812b_rx.sv
// WS2812B receive-side decoder.
// Measures high-pulse widths on the synchronized serial line, assembles 24-bit
// GRB pixels MSB first, detects the reset/latch low period, and reproduces an
// LED's pass-through: the first pixel of each frame is consumed and every later
// pixel is forwarded on dout.
module ws2812b_rx #(
  parameter int T_MIN_HIGH = 15,    // shorter high pulses are glitches
  parameter int T_THRESH   = 60,    // high width at or above this is a 1
  parameter int T_MAX_HIGH = 120,   // longer high pulses are errors
  parameter int RET_CYCLES = 5000,  // continuous low cycles forming a latch
  parameter int CNT_W      = 13,    // must hold RET_CYCLES
  parameter int PIX_W      = 16
) (
  input  logic             clk,
  input  logic             reset,        // asynchronous, active low
  input  logic             din,
  output logic [23:0]      pixel_data,
  output logic             pixel_valid,
  output logic [PIX_W-1:0] pixel_index,
  output logic             latch,
  output logic [PIX_W-1:0] frame_len,
  output logic             bit_err,
  output logic             frame_err,
  output logic             dout
);

  localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(T_MIN_HIGH);
  localparam logic [CNT_W-1:0] THRESH_W = CNT_W'(T_THRESH);
  localparam logic [CNT_W-1:0] MAX_W    = CNT_W'(T_MAX_HIGH);
  localparam logic [CNT_W-1:0] HIGH_SAT = CNT_W'(T_MAX_HIGH + 1);
  localparam logic [CNT_W-1:0] RET_W    = CNT_W'(RET_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [4:0]       LAST_BIT = 5'd23;
  localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);
  localparam logic [PIX_W-1:0] PIX_MAX  = '1;

  // Synchronizer and edge history
  logic             sync1_q, sync1_d;
  logic             din_s_q, din_s_d;
  logic             din_prev_q, din_prev_d;
  // Pulse measurement
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  // Pixel assembly; only 23 bits are held because the 24th arrives with the load
  logic [22:0]      shift_q, shift_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [PIX_W-1:0] pixel_cnt_q, pixel_cnt_d;
  logic             active_q, active_d;
  logic             fwd_en_q, fwd_en_d;
  // Registered outputs
  logic [23:0]      pixel_data_q, pixel_data_d;
  logic             pixel_valid_q, pixel_valid_d;
  logic [PIX_W-1:0] pixel_index_q, pixel_index_d;
  logic             latch_q, latch_d;
  logic [PIX_W-1:0] frame_len_q, frame_len_d;
  logic             bit_err_q, bit_err_d;
  logic             frame_err_q, frame_err_d;
  logic             dout_q, dout_d;

  logic             fall;
  logic             bit_val;

  // Next-state logic: pulse measurement, bit decode, pixel assembly, latch detection
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can leave
    // it unassigned; a missing default in always_comb would infer a latch.
    sync1_d       = din;
    din_s_d       = sync1_q;
    din_prev_d    = din_s_q;
    high_cnt_d    = high_cnt_q;
    low_cnt_d     = low_cnt_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    pixel_cnt_d   = pixel_cnt_q;
    active_d      = active_q;
    fwd_en_d      = fwd_en_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;
    pixel_index_d = pixel_index_q;
    latch_d       = 1'b0;
    frame_len_d   = frame_len_q;
    bit_err_d     = 1'b0;
    frame_err_d   = 1'b0;
    dout_d        = din_s_q & fwd_en_q;

    fall    = din_prev_q & ~din_s_q;
    bit_val = (high_cnt_q >= THRESH_W);

    // High width counts while the line is high and clears once it has fallen;
    // on the falling-edge cycle it still holds the completed width.
    if (din_s_q) begin
      high_cnt_d = (high_cnt_q == HIGH_SAT) ? high_cnt_q : high_cnt_q + CNT_ONE;
    end else begin
      high_cnt_d = '0;
    end

    if (!din_s_q) begin
      low_cnt_d = (low_cnt_q == RET_W) ? low_cnt_q : low_cnt_q + CNT_ONE;
    end else begin
      low_cnt_d = '0;
    end

    // low_cnt is zero on a falling edge, so the two branches never compete.
    if (fall) begin
      if ((high_cnt_q < MIN_W) || (high_cnt_q > MAX_W)) begin
        bit_err_d = 1'b1;
      end else begin
        active_d = 1'b1;
        shift_d  = {shift_q[21:0], bit_val};
        if (bit_cnt_q == LAST_BIT) begin
          pixel_data_d  = {shift_q, bit_val};
          pixel_valid_d = 1'b1;
          pixel_index_d = pixel_cnt_q;
          pixel_cnt_d   = (pixel_cnt_q == PIX_MAX) ? pixel_cnt_q : pixel_cnt_q + PIX_ONE;
          bit_cnt_d     = '0;
          fwd_en_d      = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
    end else if ((low_cnt_q == RET_W) && active_q) begin
      // Clearing the activity flag makes this fire once per low period.
      latch_d     = 1'b1;
      frame_len_d = pixel_cnt_q;
      frame_err_d = (bit_cnt_q != 5'd0);
      pixel_cnt_d = '0;
      bit_cnt_d   = '0;
      active_d    = 1'b0;
      fwd_en_d    = 1'b0;
    end
  end

  // State registers with asynchronous active-low clear
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every flop, including the synchronizer and the data registers,
    // is cleared so all outputs read zero for as long as reset is held.
    if (!reset) begin
      sync1_q       <= 1'b0;
      din_s_q       <= 1'b0;
      din_prev_q    <= 1'b0;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      pixel_cnt_q   <= '0;
      active_q      <= 1'b0;
      fwd_en_q      <= 1'b0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      pixel_index_q <= '0;
      latch_q       <= 1'b0;
      frame_len_q   <= '0;
      bit_err_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      dout_q        <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      din_s_q       <= din_s_d;
      din_prev_q    <= din_prev_d;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      pixel_cnt_q   <= pixel_cnt_d;
      active_q      <= active_d;
      fwd_en_q      <= fwd_en_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_index_q <= pixel_index_d;
      latch_q       <= latch_d;
      frame_len_q   <= frame_len_d;
      bit_err_q     <= bit_err_d;
      frame_err_q   <= frame_err_d;
      dout_q        <= dout_d;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_index = pixel_index_q;
  assign latch       = latch_q;
  assign frame_len   = frame_len_q;
  assign bit_err     = bit_err_q;
  assign frame_err   = frame_err_q;
  assign dout        = dout_q;

endmodule

// File: doc/ws2812b_rx.md
Name: ws2812b_rx

Overview:
Receive-side decoder for the WS2812B single-wire LED protocol, running on the 100 MHz system clock. It measures high-pulse widths on the serial line, decodes 24-bit GRB pixels MSB first, and detects the reset/latch low period. It also models a real LED's pass-through: the first pixel of each frame is consumed and later pixels are forwarded on dout. It serves as a loopback checker and in-system monitor for the transmit chain and its reset-period counter.

Parameters:
T_MIN_HIGH, 15, minimum valid high width in clk cycles; shorter pulses are glitches.
T_THRESH, 60, high width at or above this decodes as 1; below decodes as 0.
T_MAX_HIGH, 120, maximum valid high width; longer pulses are errors.
RET_CYCLES, 5000, continuous low cycles that constitute a reset/latch (50 us).
CNT_W, 13, width of the low/high counters; must hold RET_CYCLES.
PIX_W, 16, width of the pixel counter and frame_len.

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-low reset
din  input  1  WS2812B serial line, asynchronous to clk
pixel_data  output  24  last decoded pixel, GRB, bit 23 received first
pixel_valid  output  1  one-cycle pulse when pixel_data updates
pixel_index  output  PIX_W  index within the frame of the pixel on pixel_data, starting at 0
latch  output  1  one-cycle pulse on reset-period detection
frame_len  output  PIX_W  pixels received in the frame just latched
bit_err  output  1  one-cycle pulse on a glitch or over-long high pulse
frame_err  output  1  one-cycle pulse when a latch occurs with a partial pixel pending
dout  output  1  forwarded stream

Behaviour:
- Reset is asynchronous and active-low: reset==0 immediately clears every register. While in reset, all outputs are 0, the synchronizer is 0, and all counters, the shift register and the forwarding enable are cleared.
- din passes through a 2-flop synchronizer to produce din_s. All decoding uses din_s.
- high_cnt increments while din_s==1, saturating at T_MAX_HIGH+1, and clears on the cycle after din_s falls.
- low_cnt increments while din_s==0, saturating at RET_CYCLES, and clears when din_s==1.
- Falling edge of din_s (previous din_s 1, current din_s 0), with width w = high_cnt:
  - w < T_MIN_HIGH or w > T_MAX_HIGH: pulse bit_err; no shift; bit_cnt unchanged.
  - otherwise: bit = (w >= T_THRESH); shift the bit in; bit_cnt += 1; set the activity flag.
  - on the 24th valid bit: on the same clock edge, load pixel_data with the full word, pulse pixel_valid, drive pixel_index = pixel_cnt, increment pixel_cnt (saturating at all ones), reset bit_cnt to 0, and set fwd_en.
- Latency: pixel_valid is high during the 3rd clk cycle after the rising edge at which din is first sampled low after the 24th high pulse (2 synchronizer cycles plus 1 register cycle).
- Latch:
  - Fires when low_cnt reaches RET_CYCLES and the activity flag is set.
  - latch pulses for 1 cycle and frame_len <= pixel_cnt.
  - frame_err pulses in the same cycle if bit_cnt != 0.
  - pixel_cnt, bit_cnt, the activity flag and fwd_en are cleared.
  - Fires at most once per continuous low period; no latch fires after reset until at least one valid bit has been received.
- Forwarding: dout is a register. dout <= din_s & fwd_en, so dout stays 0 throughout the first pixel and mirrors din with 3-cycle latency from the next high pulse until the latch.
- Simultaneous events:
  - A falling edge and low_cnt reaching RET_CYCLES cannot coincide, because low_cnt is 0 at a falling edge.
  - bit_err and pixel_valid never pulse in the same cycle.
- A high pulse still in progress when reset deasserts counts from the first synchronized sample. Such a partial first pulse may yield bit_err; this is the required behaviour.
- pixel_data and frame_len hold their values until the next update.

Test Plan:
1. Reset, then one pixel 0xA50F3C (0 = 40 high/85 low, 1 = 85 high/40 low), then 5000 low -> exactly one pixel_valid with pixel_data=0xA50F3C and pixel_index=0; latch 5000+2 cycles after din falls; frame_len=1; no bit_err/frame_err; dout stays 0.
2. Three pixels 0x123456, 0xFFFFFF, 0x000000, then ret -> three pixel_valids, index 0,1,2, at the stated 3-cycle latency; dout=0 through pixel 0, then equals din delayed 3 cycles for pixels 1-2; frame_len=3.
3. A 10-cycle high glitch inserted between bits 7 and 8 of 0xA50F3C -> bit_err once; pixel still decodes as 0xA50F3C. A separate 130-cycle high -> bit_err once, bit dropped.
4. 10 valid bits, then 5000 low -> latch plus frame_err in the same cycle; frame_len=0; no pixel_valid. The next full pixel decodes correctly at index 0.
5. Low gaps of 4999 cycles between bits -> no latch and pixel intact. A gap of 5000 cycles -> latch. 20000 low cycles -> only one latch. After reset with din idle low -> no latch.
6. reset driven low mid-pixel (bit 12) asynchronously, between clock edges -> all outputs 0 immediately. After release, a fresh pixel 0x00FF00 decodes with index 0 and no frame_err.
